// File: rtl/mesh_pkg.sv
// Shared mesh definitions: flit geometry, flit type and tile ID width.
package mesh_pkg;

  localparam int unsigned FLIT_W         = 34;
  localparam int unsigned FLIT_VALID_BIT = 33;
  localparam int unsigned TILE_ID_W      = 2;

  typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/mesh_flit_fifo.sv
// Circular flit store: memory array, wrapping read/write pointers and occupancy count.
// The caller guarantees i_push only when not full and i_pop only when not empty.
module mesh_flit_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_mem [DEPTH];

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/mesh_link_buffer.sv
// Elastic flit buffer on an inter-tile mesh link with ready back-pressure.
// Optional statistics counters (drop/pass) are enabled by defining MESH_LINK_STATS_EN.
module mesh_link_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned FLIT_W = mesh_pkg::FLIT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              in_ready,
  output logic [FLIT_W-1:0] out_flit,
  input  logic              out_ready,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       pass_cnt
);

  import mesh_pkg::*;

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic              w_in_valid;
  logic              w_push;
  logic              w_pop;
  logic              w_not_empty;
  logic [FLIT_W-2:0] w_head;
  logic [AW:0]       w_count;

  // Only the payload is stored: the valid bit of a buffered flit is always 1.
  assign w_in_valid  = in_flit[FLIT_W-1];
  assign w_not_empty = (w_count != '0);
  assign in_ready    = (w_count != FULL_CNT);
  assign w_push      = w_in_valid && in_ready;
  assign w_pop       = w_not_empty && out_ready;

  mesh_flit_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FLIT_W-1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (in_flit[FLIT_W-2:0]),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Present the head flit with valid forced high, or all zeros when empty.
  always_comb begin
    out_flit = '0;
    if (w_not_empty) out_flit = {1'b1, w_head};
  end

`ifdef MESH_LINK_STATS_EN
  logic        w_drop;
  logic [15:0] r_drop_cnt;
  logic [15:0] r_pass_cnt;

  assign w_drop = w_in_valid && !in_ready;

  // Saturating drop and pass counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
      r_pass_cnt <= '0;
    end else begin
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
      if (w_pop  && (r_pass_cnt != '1)) r_pass_cnt <= r_pass_cnt + 1'b1;
    end
  end

  assign drop_cnt = r_drop_cnt;
  assign pass_cnt = r_pass_cnt;
`else
  assign drop_cnt = '0;
  assign pass_cnt = '0;
`endif

endmodule

// File: tb/tb_mesh_link_buffer.sv
// Scoreboard bench for mesh_link_buffer: driver predicts per-cycle outputs from a
// queue-based FIFO model, monitor compares DUT outputs against the predictions.
module tb_mesh_link_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [33:0] in_flit = '0;
  logic        in_ready;
  logic [33:0] out_flit;
  logic        out_ready = 1'b0;
  logic [15:0] drop_cnt;
  logic [15:0] pass_cnt;

  mesh_link_buffer #(.DEPTH(DEPTH), .FLIT_W(34)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_flit   (in_flit),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_ready (out_ready),
    .drop_cnt  (drop_cnt),
    .pass_cnt  (pass_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [33:0] flit;
    logic        rdy;
    logic [15:0] drop;
    logic [15:0] pass;
  } exp_t;

  exp_t        exp_q[$];
  logic [32:0] model_q[$];
  int unsigned m_drop = 0;
  int unsigned m_pass = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  // One cycle of stimulus: drive at negedge, predict what the DUT shows this cycle,
  // then advance the model to what the next rising edge will do.
  task automatic drive(input bit rstn, input bit vld, input logic [32:0] pl, input bit ordy);
    exp_t e;
    @(negedge clk);
    rst_n     = rstn;
    in_flit   = {vld, pl};
    out_ready = ordy;
    if (!rstn) begin
      model_q.delete();
      m_drop = 0;
      m_pass = 0;
    end
    e.rdy  = (model_q.size() < DEPTH);
    e.flit = (model_q.size() != 0) ? {1'b1, model_q[0]} : 34'h0;
`ifdef MESH_LINK_STATS_EN
    e.drop = 16'(m_drop);
    e.pass = 16'(m_pass);
`else
    e.drop = 16'h0;
    e.pass = 16'h0;
`endif
    exp_q.push_back(e);
    if (rstn) begin
      bit can_push;
      can_push = (model_q.size() < DEPTH);
      if (model_q.size() != 0 && ordy) begin
        void'(model_q.pop_front());
        if (m_pass != 16'hFFFF) m_pass++;
      end
      if (vld) begin
        if (can_push) model_q.push_back(pl);
        else if (m_drop != 16'hFFFF) m_drop++;
      end
    end
  endtask

  // Monitor: after the driver has set this cycle's inputs, compare DUT outputs.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_checks++;
        if (out_flit !== e.flit) begin
          n_fail++;
          $display("FAIL out_flit t=%0t got=%h exp=%h", $time, out_flit, e.flit);
        end
        n_checks++;
        if (in_ready !== e.rdy) begin
          n_fail++;
          $display("FAIL in_ready t=%0t got=%b exp=%b", $time, in_ready, e.rdy);
        end
        n_checks++;
        if (drop_cnt !== e.drop) begin
          n_fail++;
          $display("FAIL drop_cnt t=%0t got=%0d exp=%0d", $time, drop_cnt, e.drop);
        end
        n_checks++;
        if (pass_cnt !== e.pass) begin
          n_fail++;
          $display("FAIL pass_cnt t=%0t got=%0d exp=%0d", $time, pass_cnt, e.pass);
        end
      end
    end
  end

  initial begin
    // Reset with a valid flit held on the input, then release.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 33'h0_0000_0001, 1'b0);
    drive(1'b1, 1'b1, 33'h0_0000_0001, 1'b0);
    drive(1'b1, 1'b0, 33'h0, 1'b0);
    drive(1'b1, 1'b0, 33'h0, 1'b1);
    drive(1'b1, 1'b0, 33'h0, 1'b1);

    // Fill with back-pressure, one drop, then drain.
    for (int i = 1; i <= 5; i++) drive(1'b1, 1'b1, 33'(i), 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 33'h0, 1'b1);

    // Streaming with pointer wrap-around.
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 33'(i), 1'b1);
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 33'h0, 1'b1);

    // Full buffer with simultaneous push and pop: push is dropped.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 33'(32'h100 + i), 1'b0);
    drive(1'b1, 1'b1, 33'h0AA, 1'b1);
    drive(1'b1, 1'b0, 33'h0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 33'h0, 1'b1);

    // Empty with pop attempts.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 33'h0, 1'b1);

    // Mid-stream reset with three flits buffered.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 33'(32'h200 + i), 1'b0);
    drive(1'b0, 1'b0, 33'h0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 33'h0, 1'b1);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      bit          r_vld, r_ordy, r_rst;
      logic [32:0] r_pl;
      r_vld  = ($urandom_range(0, 3) != 0);
      r_ordy = ($urandom_range(0, 2) != 0);
      r_rst  = ($urandom_range(0, 63) == 0);
      r_pl   = {1'($urandom), 32'($urandom)};
      drive(!r_rst, r_vld, r_pl, r_ordy);
    end
    drive(1'b1, 1'b0, 33'h0, 1'b1);

    // Let the monitor consume the remaining predictions, bounded.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
